rect_ctl: RTL and testbench

- Frame-synchronous position and visibility controller for the rectangle overlay stage.
- Samples direction and show keys, then updates rectangle X/Y and enable exactly once per frame at the start of vertical blanking. Position therefore never changes during active video.
- Applies a slow/fast step profile while keys are held, and clamps the rectangle inside the visible area.
- Outputs feed the rectangle draw stage's position and enable inputs.

---
 rtl/vga_pkg.sv | 11 +
 rtl/edge_rise.sv | 11 +
 rtl/rect_ctl.sv | 86 ++++++++
 tb/tb_rect_ctl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: screen/rectangle geometry defaults and rect_ctl motion profile
package vga_pkg;
  localparam int HOR_PIXELS  = 800;
  localparam int VER_PIXELS  = 600;
  localparam int RECT_WIDTH  = 48;
  localparam int RECT_HEIGHT = 64;
  localparam int STEP_SLOW   = 1;
  localparam int STEP_FAST   = 4;
  localparam int HOLD_FRAMES = 16;
  typedef enum logic [1:0] {IDLE, MOVE_SLOW, MOVE_FAST} rect_state_e;
endpackage

// File: rtl/edge_rise.sv
// edge_rise: registers its input and flags the cycle where it goes 0->1
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic d_q;
  always_ff @(posedge clk) d_q <= rst ? 1'b0 : d;
  assign rise = d & ~d_q;
endmodule

// File: rtl/rect_ctl.sv
// rect_ctl: per-frame rectangle position/visibility update at start of vblank
module rect_ctl
  import vga_pkg::*;
#(
  parameter int SCREEN_W    = HOR_PIXELS,
  parameter int SCREEN_H    = VER_PIXELS,
  parameter int RECT_W      = RECT_WIDTH,
  parameter int RECT_H      = RECT_HEIGHT,
  parameter int X_INIT      = 0,
  parameter int Y_INIT      = 0,
  parameter int STEP_SLOW_P = STEP_SLOW,
  parameter int STEP_FAST_P = STEP_FAST,
  parameter int HOLD_FRAMES_P = HOLD_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_show,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        rect_en
);
  localparam int HW = $clog2(HOLD_FRAMES_P + 1);
  localparam logic [12:0] X_MAX = 13'(SCREEN_W - RECT_W);
  localparam logic [12:0] Y_MAX = 13'(SCREEN_H - RECT_H);
  rect_state_e state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic en_q, en_d, tog_q, tog_d;
  logic tick, show_rise;
  logic lf, rt, up, dn, moving, fast, tog;
  logic [12:0] step, nx, ny;
  edge_rise u_vblnk (.clk(clk), .rst(rst), .d(vblnk),    .rise(tick));
  edge_rise u_show  (.clk(clk), .rst(rst), .d(key_show), .rise(show_rise));
  always_comb begin
    lf = key_left & ~key_right;
    rt = key_right & ~key_left;
    up = key_up & ~key_down;
    dn = key_down & ~key_up;
    moving = lf | rt | up | dn;
    fast = (state_q == MOVE_FAST) || (state_q == MOVE_SLOW && hold_q == HW'(HOLD_FRAMES_P));
    step = fast ? 13'(STEP_FAST_P) : 13'(STEP_SLOW_P);
    // 13-bit sum: a negative result shows up as bit 12 set
    nx = {1'b0, x_q} + (rt ? step : lf ? 13'd0 - step : 13'd0);
    ny = {1'b0, y_q} + (dn ? step : up ? 13'd0 - step : 13'd0);
    tog = tog_q ^ show_rise;
    state_d = state_q;
    hold_d = hold_q;
    x_d = x_q;
    y_d = y_q;
    en_d = en_q;
    tog_d = tog;
    if (tick) begin
      en_d = en_q ^ tog;
      tog_d = 1'b0;
      state_d = !moving ? IDLE : fast ? MOVE_FAST : MOVE_SLOW;
      hold_d = !moving ? '0 : (state_q == IDLE) ? HW'(1) : (state_q == MOVE_SLOW && !fast) ? hold_q + HW'(1) : hold_q;
      x_d = nx[12] ? 12'd0 : (nx > X_MAX) ? X_MAX[11:0] : nx[11:0];
      y_d = ny[12] ? 12'd0 : (ny > Y_MAX) ? Y_MAX[11:0] : ny[11:0];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q <= '0;
      x_q <= 12'(X_INIT);
      y_q <= 12'(Y_INIT);
      en_q <= 1'b0;
      tog_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      x_q <= x_d;
      y_q <= y_d;
      en_q <= en_d;
      tog_q <= tog_d;
    end
  end
  assign xpos = x_q;
  assign ypos = y_q;
  assign rect_en = en_q;
endmodule

// File: tb/tb_rect_ctl.sv
// tb_rect_ctl: scoreboard bench for rect_ctl frame-synchronous updates
module tb_rect_ctl;
  logic clk = 1'b0, rst = 1'b1, vblnk = 1'b0;
  logic key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0, key_show = 1'b0;
  logic [11:0] xpos, ypos;
  logic rect_en;
  int total = 0, bad = 0;
  typedef struct packed {logic [11:0] x; logic [11:0] y; logic en;} exp_t;
  exp_t sb[$];
  int mx = 0, my = 0, mst = 0, mhold = 0;
  bit men = 0, mtog = 0;

  rect_ctl dut (
    .clk(clk), .rst(rst), .vblnk(vblnk),
    .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
    .key_show(key_show), .xpos(xpos), .ypos(ypos), .rect_en(rect_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mst = 0; mhold = 0; men = 0; mtog = 0;
  endtask

  task automatic model_tick(input bit l, input bit r, input bit u, input bit d);
    bit lf, rt, up, dn, fast;
    int step;
    exp_t e;
    lf = l & ~r; rt = r & ~l; up = u & ~d; dn = d & ~u;
    fast = (mst == 2) || (mst == 1 && mhold == 16);
    step = fast ? 4 : 1;
    if (!(lf | rt | up | dn)) begin
      mst = 0; mhold = 0;
    end else begin
      mx = mx + (rt ? step : lf ? -step : 0);
      my = my + (dn ? step : up ? -step : 0);
      mx = mx < 0 ? 0 : mx > 752 ? 752 : mx;
      my = my < 0 ? 0 : my > 536 ? 536 : my;
      mhold = (mst == 0) ? 1 : (mst == 1 && !fast) ? mhold + 1 : mhold;
      mst = fast ? 2 : 1;
    end
    men = men ^ mtog;
    mtog = 0;
    e.x = mx[11:0]; e.y = my[11:0]; e.en = men;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_x"}, xpos, e.x);
    check({tag, "_y"}, ypos, e.y);
    check({tag, "_en"}, rect_en, e.en);
  endtask

  task automatic frame(input bit l, input bit r, input bit u, input bit d, input int presses, input bit at_tick);
    {key_left, key_right, key_up, key_down} = {l, r, u, d};
    @(negedge clk);
    @(negedge clk);
    repeat (presses) begin
      key_show = 1'b1; mtog ^= 1'b1;
      @(negedge clk);
      key_show = 1'b0;
      @(negedge clk);
    end
    vblnk = 1'b1;
    if (at_tick) begin
      key_show = 1'b1; mtog ^= 1'b1;
    end
    check("pre_x", xpos, mx);
    check("pre_y", ypos, my);
    check("pre_en", rect_en, men);
    model_tick(l, r, u, d);
    @(negedge clk);
    pop_chk("tick");
    key_show = 1'b0;
    @(negedge clk);
    check("hold_x", xpos, mx);
    vblnk = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_x", xpos, 0);
    check("rst_y", ypos, 0);
    check("rst_en", rect_en, 0);
    rst = 1'b0;
    model_reset();
    repeat (3) frame(0, 0, 0, 0, 0, 0);
    repeat (20) frame(0, 1, 0, 0, 0, 0);
    check("right20_x", xpos, 32);
    frame(1, 1, 0, 0, 0, 0);
    check("lr_cancel_x", xpos, 32);
    frame(0, 1, 0, 0, 0, 0);
    check("resume_slow_x", xpos, 33);
    frame(0, 0, 0, 0, 2, 0);
    check("two_press_en", rect_en, 0);
    frame(0, 0, 0, 0, 1, 0);
    check("one_press_en", rect_en, 1);
    frame(0, 0, 0, 0, 0, 1);
    check("tick_press_en", rect_en, 0);
    repeat (3) frame(0, 0, 0, 1, 0, 0);
    check("down3_y", ypos, 3);
    repeat (5) frame(0, 0, 1, 0, 0, 0);
    check("up_clamp_y", ypos, 0);
    repeat (200) frame(0, 1, 0, 0, 0, 0);
    check("right_clamp_x", xpos, 752);
    frame(0, 0, 0, 0, 1, 0);
    frame(0, 1, 0, 0, 0, 0);
    rst = 1'b1; vblnk = 1'b1; key_right = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_x", xpos, 0);
    check("mid_rst_en", rect_en, 0);
    model_reset();
    rst = 1'b0;
    model_tick(0, 1, 0, 0);
    @(negedge clk);
    pop_chk("post_rst");
    check("post_rst_slow_x", xpos, 1);
    vblnk = 1'b0; key_right = 1'b0;
    @(negedge clk);
    repeat (2) frame(1, 0, 0, 0, 0, 0);
    check("left_clamp_x", xpos, 0);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
